// File: rtl/alu_flag_if.sv
// Bundle between the add/sub datapath, branch unit and the Z/V/N flag unit.
// Master drives the datapath/branch side; slave is the flag unit itself.
interface alu_flag_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic              en;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ovfl;
  logic              upd_z;
  logic              upd_v;
  logic              upd_n;
  logic              br_valid;
  logic [2:0]        cond;
  logic              sat_clr;
  logic              flag_z;
  logic              flag_v;
  logic              flag_n;
  logic              br_taken;
  logic [CNT_W-1:0]  sat_cnt;

  modport master (
    output en, alu_result, alu_ovfl, upd_z, upd_v, upd_n, br_valid, cond, sat_clr,
    input  flag_z, flag_v, flag_n, br_taken, sat_cnt
  );

  modport slave (
    input  en, alu_result, alu_ovfl, upd_z, upd_v, upd_n, br_valid, cond, sat_clr,
    output flag_z, flag_v, flag_n, br_taken, sat_cnt
  );
endinterface

// File: rtl/alu_flag_unit.sv
// Z/V/N condition flag registers, branch condition resolution and a saturating
// overflow-event counter. Optional macro FLAG_BYPASS_EN forwards same-cycle flag updates to branch resolution.
module alu_flag_unit #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input logic        clk,
  input logic        rst,
  alu_flag_if.slave  bus
);
  localparam logic [2:0] COND_NEQ    = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_GT     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_GTE    = 3'b100;
  localparam logic [2:0] COND_LTE    = 3'b101;
  localparam logic [2:0] COND_OVFL   = 3'b110;
  localparam logic [2:0] COND_UNCOND = 3'b111;

  logic             z_q, v_q, n_q;
  logic [CNT_W-1:0] cnt_q;
  logic             z_new, n_new;
  logic             z_sel, v_sel, n_sel;
  logic             taken;

  assign z_new = (bus.alu_result == '0);
  assign n_new = bus.alu_result[DATA_W-1];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q <= 1'b0;
      v_q <= 1'b0;
      n_q <= 1'b0;
    end else if (bus.en) begin
      if (bus.upd_z) z_q <= z_new;
      if (bus.upd_v) v_q <= bus.alu_ovfl;
      if (bus.upd_n) n_q <= n_new;
    end
  end

  // Clear beats an overflow event in the same cycle; count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.en) begin
      if (bus.sat_clr)
        cnt_q <= '0;
      else if (bus.upd_v && bus.alu_ovfl && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef FLAG_BYPASS_EN
  assign z_sel = (bus.en && bus.upd_z) ? z_new        : z_q;
  assign v_sel = (bus.en && bus.upd_v) ? bus.alu_ovfl : v_q;
  assign n_sel = (bus.en && bus.upd_n) ? n_new        : n_q;
`else
  assign z_sel = z_q;
  assign v_sel = v_q;
  assign n_sel = n_q;
`endif

  // NOTE: combinational outputs get a default before the case so no path
  // through the block leaves them unassigned (which would infer a latch).
  always_comb begin
    taken = 1'b0;
    if (bus.br_valid) begin
      case (bus.cond)
        COND_NEQ:    taken = !z_sel;
        COND_EQ:     taken = z_sel;
        COND_GT:     taken = !z_sel && !n_sel;
        COND_LT:     taken = n_sel;
        COND_GTE:    taken = z_sel || !n_sel;
        COND_LTE:    taken = z_sel || n_sel;
        COND_OVFL:   taken = v_sel;
        COND_UNCOND: taken = 1'b1;
        default:     taken = 1'b0;
      endcase
    end
  end

  assign bus.flag_z   = z_q;
  assign bus.flag_v   = v_q;
  assign bus.flag_n   = n_q;
  assign bus.sat_cnt  = cnt_q;
  assign bus.br_taken = taken;
endmodule

// File: doc/alu_flag_unit.md
Name: alu_flag_unit

Overview:
- Sits directly downstream of the 16-bit saturating add/sub datapath.
- Consumes its 16-bit result and overflow flag, and holds the processor's Z/V/N condition flags in registers.
- Resolves the 3-bit branch condition code against the stored flags for the branch unit.
- Keeps a saturating count of arithmetic overflow (saturation) events for debug and performance visibility.

Parameters:
- DATA_W, 16, width of the ALU result input.
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  write enable (low = stall). When low, all registered state holds.
- alu_result  input  DATA_W  result from the add/sub/logic datapath; already saturated when applicable.
- alu_ovfl  input  1  overflow indication from the add/sub datapath.
- upd_z  input  1  the current instruction updates Z (ADD, SUB, XOR, SLL, SRA, ROR).
- upd_v  input  1  the current instruction updates V (ADD, SUB only).
- upd_n  input  1  the current instruction updates N (ADD, SUB only).
- br_valid  input  1  a conditional branch is being evaluated this cycle.
- cond  input  3  branch condition code.
- sat_clr  input  1  synchronous clear of the saturation counter.
- flag_z  output  1  registered zero flag.
- flag_v  output  1  registered overflow flag.
- flag_n  output  1  registered negative flag.
- br_taken  output  1  branch decision (combinational).
- sat_cnt  output  CNT_W  saturation event count.

Behaviour:
- Reset (async, rst=1): flag_z=0, flag_v=0, flag_n=0, sat_cnt=0. The counter clear is immediate, not clock-gated. br_taken=0 while br_valid=0.
- Flag capture: on a rising edge with en=1:
  - if upd_z, flag_z <= (alu_result == 0);
  - if upd_v, flag_v <= alu_ovfl;
  - if upd_n, flag_n <= alu_result[DATA_W-1].
- Each flag updates independently. A flag whose upd_* bit is low holds its value. Latency: 1 cycle from input to flag output.
- N on a saturated result is taken from the saturated value: 0x7FFF gives N=0, 0x8000 gives N=1.
- en=0: no flag update and no counter change, regardless of upd_*, alu_ovfl or sat_clr.
- Branch resolution is combinational from the flag values selected by the bypass rule. br_taken=0 whenever br_valid=0. With br_valid=1:
  - 000 NEQ: Z==0
  - 001 EQ: Z==1
  - 010 GT: Z==0 and N==0
  - 011 LT: N==1
  - 100 GTE: Z==1 or N==0
  - 101 LTE: Z==1 or N==1
  - 110 OVFL: V==1
  - 111 UNCOND: 1
- Saturation counter: on a rising edge with en=1, sat_clr takes priority and sets sat_cnt <= 0. Otherwise, if upd_v=1 and alu_ovfl=1, sat_cnt increments by 1.
  - The counter saturates at all-ones and never wraps.
  - Simultaneous sat_clr and an overflow event: result is 0; the event is dropped.
- alu_ovfl with upd_v=0 is ignored by both flag_v and the counter.
- Reset asserted mid-stall or mid-branch: state clears immediately. br_taken then re-evaluates from the reset flags (UNCOND still gives 1 if br_valid=1).

Optional Feature:
- Macro FLAG_BYPASS_EN.
- Defined: when en=1 and upd_x=1 in the same cycle, branch resolution uses the incoming value for that flag (computed from alu_result/alu_ovfl) instead of the registered flag_x. This supports same-cycle compare-and-branch in a pipelined build. Flags with upd_x=0 still use their registered value. The flag_* outputs remain registered-only.
- Undefined: branch resolution always uses the registered flags; no combinational path from alu_result/alu_ovfl to br_taken exists.

Test Plan:
- Reset: assert rst mid-cycle with flags previously 1/1/1 and sat_cnt=5 -> outputs 0/0/0 and sat_cnt=0 without waiting for a clock edge; br_valid=1, cond=111 -> br_taken=1; cond=110 -> 0.
- Flag capture: en=1, all upd=1, alu_result=0x0000, alu_ovfl=0 -> next cycle Z=1, N=0, V=0. Then alu_result=0x8000, alu_ovfl=1 -> Z=0, N=1, V=1. Then alu_result=0x7FFF, upd_z=1 only -> Z=0, while N=1 and V=1 hold.
- Branch table: force each Z/N/V combination, sweep cond 000-111 with br_valid=1 -> br_taken matches the table. Example: Z=0, N=0 gives GT=1, LTE=0. With br_valid=0 -> br_taken=0 for all codes.
- Stall: en=0 with upd_*=1, alu_result=0, alu_ovfl=1, sat_clr=1 for 3 cycles -> flags and sat_cnt unchanged.
- Counter: 4 overflow events with upd_v=1 -> sat_cnt=4. An overflow with upd_v=0 -> still 4. sat_clr together with an overflow -> 0. Preload to 0xFFFE, then 3 events -> 0xFFFF, held.
- Bypass (FLAG_BYPASS_EN defined): registered Z=0, same cycle en=1, upd_z=1, alu_result=0, br_valid=1, cond=001 -> br_taken=1. Same stimulus with the macro undefined -> br_taken=0.
